// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the fetch stage
package cpu_pkg;

  // All-zero word decodes as sll $0,$0,0 and is used as the pipeline bubble
  localparam logic [31:0] NOP_INSTR = 32'h0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam int JUMP_W = 26;
  localparam int IMM_W  = 16;

  // What the IF/ID register does on the coming edge
  typedef enum logic [1:0] {
    IF_HOLD    = 2'd0,  // keep every IF/ID field
    IF_BUBBLE  = 2'd1,  // zero the instruction and clear valid, keep PC metadata
    IF_CAPTURE = 2'd2   // load the ROM word and its PC metadata
  } if_sel_e;

endpackage

// File: rtl/pc_next.sv
// rtl/pc_next.sv - combinational next-PC and IF/ID load selection
module pc_next
  import cpu_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 32
) (
  input  logic [N-1:0]      pc_i,
  input  logic [N-1:0]      if_pc_plus1_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              branch_taken_i,
  input  logic [IMM_W-1:0]  branch_offset_i,
  input  logic              jump_i,
  input  logic [JUMP_W-1:0] jump_target_i,
  output logic [N-1:0]      pc_d_o,
  output logic [N-1:0]      pc_plus1_o,
  output if_sel_e           sel_o,
  output logic              err_set_o
);

  localparam logic [N-1:0] DEPTH_N = N'(DEPTH);

  logic [N-1:0] branch_tgt;
  logic [N-1:0] jump_tgt;

  assign pc_plus1_o = pc_i + N'(1);
  assign branch_tgt = if_pc_plus1_i + {{(N - IMM_W){branch_offset_i[IMM_W-1]}}, branch_offset_i};

  // Jump keeps the upper region bits of the sequential successor of the jump itself
  always_comb begin
    jump_tgt               = if_pc_plus1_i;
    jump_tgt[JUMP_W-1:0]   = jump_target_i;
  end

  // Priority: jump, branch, stall, out-of-range, flush, normal fetch
  always_comb begin
    pc_d_o    = pc_i;
    sel_o     = IF_HOLD;
    err_set_o = 1'b0;
    if (jump_i) begin
      pc_d_o = jump_tgt;
      sel_o  = IF_BUBBLE;
    end else if (branch_taken_i) begin
      pc_d_o = branch_tgt;
      sel_o  = IF_BUBBLE;
    end else if (stall_i) begin
      // a flush arriving during a stall still kills the held instruction
      sel_o = flush_i ? IF_BUBBLE : IF_HOLD;
    end else if (pc_i >= DEPTH_N) begin
      // park on the bad address until a redirect pulls the PC back
      sel_o     = IF_BUBBLE;
      err_set_o = 1'b1;
    end else if (flush_i) begin
      pc_d_o = pc_plus1_o;
      sel_o  = IF_BUBBLE;
    end else begin
      pc_d_o = pc_plus1_o;
      sel_o  = IF_CAPTURE;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC and IF/ID register
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int N        = 32,
  parameter int DEPTH    = 32,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              branch_taken,
  input  logic [IMM_W-1:0]  branch_offset,
  input  logic              jump,
  input  logic [JUMP_W-1:0] jump_target,
  output logic [N-1:0]      rom_addr,
  input  logic [N-1:0]      rom_instr,
  output logic [N-1:0]      if_instr,
  output logic [N-1:0]      if_pc,
  output logic [N-1:0]      if_pc_plus1,
  output logic              if_valid,
  output logic              pc_err
);

  logic [N-1:0] pc_q, pc_d, pc_plus1;
  logic [N-1:0] if_instr_q, if_instr_d;
  logic [N-1:0] if_pc_q, if_pc_d;
  logic [N-1:0] if_pc_plus1_q, if_pc_plus1_d;
  logic         if_valid_q, if_valid_d;
  logic         pc_err_q, pc_err_d;
  if_sel_e      sel;
  logic         err_set;

  pc_next #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_pc_next (
    .pc_i            (pc_q),
    .if_pc_plus1_i   (if_pc_plus1_q),
    .stall_i         (stall),
    .flush_i         (flush),
    .branch_taken_i  (branch_taken),
    .branch_offset_i (branch_offset),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .pc_d_o          (pc_d),
    .pc_plus1_o      (pc_plus1),
    .sel_o           (sel),
    .err_set_o       (err_set)
  );

  // IF/ID next state from the selected load action; error flag is sticky
  always_comb begin
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_pc_plus1_d = if_pc_plus1_q;
    if_valid_d    = if_valid_q;
    pc_err_d      = pc_err_q | err_set;
    case (sel)
      IF_CAPTURE: begin
        if_instr_d    = rom_instr;
        if_pc_d       = pc_q;
        if_pc_plus1_d = pc_plus1;
        if_valid_d    = 1'b1;
      end
      IF_BUBBLE: begin
        if_instr_d = N'(NOP_INSTR);
        if_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // State registers; reset beats every redirect and stall
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= N'(RESET_PC);
      if_instr_q    <= N'(NOP_INSTR);
      if_pc_q       <= '0;
      if_pc_plus1_q <= '0;
      if_valid_q    <= 1'b0;
      pc_err_q      <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus1_q <= if_pc_plus1_d;
      if_valid_q    <= if_valid_d;
      pc_err_q      <= pc_err_d;
    end
  end

  assign rom_addr    = pc_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus1 = if_pc_plus1_q;
  assign if_valid    = if_valid_q;
  assign pc_err      = pc_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized checks of fetch_unit against a reference model
module tb_fetch_unit;

  localparam int N     = 32;
  localparam int DEPTH = 32;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic [31:0] rom_addr;
  logic [31:0] rom_instr;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus1;
  logic        if_valid;
  logic        pc_err;

  logic [31:0] mem [0:DEPTH-1];

  // reference model state
  logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc1;
  logic        m_valid, m_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  fetch_unit #(.N(N), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .rom_addr      (rom_addr),
    .rom_instr     (rom_instr),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_pc_plus1   (if_pc_plus1),
    .if_valid      (if_valid),
    .pc_err        (pc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM returns garbage off the end so a wrongly captured word is visible
  assign rom_instr = (rom_addr < DEPTH) ? mem[rom_addr[4:0]] : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".rom_addr"},    rom_addr,    m_pc);
    chk({tag, ".if_instr"},    if_instr,    m_instr);
    chk({tag, ".if_pc"},       if_pc,       m_ifpc);
    chk({tag, ".if_pc_plus1"}, if_pc_plus1, m_ifpc1);
    chk({tag, ".if_valid"},    32'(if_valid), 32'(m_valid));
    chk({tag, ".pc_err"},      32'(pc_err),   32'(m_err));
  endtask

  // Advance one edge: model evaluates the spec's priority rules on the current inputs
  task automatic step(input string tag);
    logic [31:0] tgt;
    if (rst) begin
      m_pc = 0; m_instr = 0; m_ifpc = 0; m_ifpc1 = 0; m_valid = 0; m_err = 0;
    end else if (jump || branch_taken) begin
      if (jump) tgt = {m_ifpc1[31:26], jump_target};
      else      tgt = m_ifpc1 + 32'(int'($signed(branch_offset)));
      m_pc = tgt; m_instr = 0; m_valid = 0;
    end else if (stall) begin
      if (flush) begin m_instr = 0; m_valid = 0; end
    end else if (m_pc >= DEPTH) begin
      m_err = 1; m_instr = 0; m_valid = 0;
    end else if (flush) begin
      m_pc = m_pc + 1; m_instr = 0; m_valid = 0;
    end else begin
      m_instr = mem[m_pc]; m_ifpc = m_pc; m_ifpc1 = m_pc + 1; m_valid = 1;
      m_pc = m_pc + 1;
    end
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; flush = 0; branch_taken = 0; branch_offset = 0;
    jump = 0; jump_target = 0;
  endtask

  initial begin
    int o;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom | 32'h1;
    mem[2] = 32'h8C01_0001;
    idle_inputs();
    m_pc = 0; m_instr = 0; m_ifpc = 0; m_ifpc1 = 0; m_valid = 0; m_err = 0;

    // reset and startup
    rst = 1;
    step("reset0");
    step("reset1");
    chk("reset_rom_addr", rom_addr, 32'd0);
    chk("reset_valid", 32'(if_valid), 32'd0);
    chk("reset_instr", if_instr, 32'd0);
    rst = 0;
    step("start1");
    step("start2");
    step("start3");
    chk("start_instr", if_instr, 32'h8C01_0001);
    chk("start_pc", if_pc, 32'd2);
    chk("start_pc1", if_pc_plus1, 32'd3);

    // branch back by two words from if_pc_plus1=3
    branch_taken = 1; branch_offset = 16'hFFFE;
    step("branch");
    chk("branch_pc", rom_addr, 32'd1);
    chk("branch_bubble", 32'(if_valid), 32'd0);
    idle_inputs();
    step("branch_resume");
    chk("branch_resume_pc", if_pc, 32'd1);
    step("seq2");
    step("seq3");

    // stall while pc=4
    chk("pre_stall_pc", rom_addr, 32'd4);
    stall = 1;
    for (int i = 0; i < 3; i++) step("stall");
    chk("stall_hold_if_pc", if_pc, 32'd3);
    stall = 0;
    step("stall_release");
    chk("stall_release_pc", if_pc, 32'd4);
    chk("stall_release_instr", if_instr, mem[4]);

    // jump wins over branch
    jump = 1; jump_target = 26'd7; branch_taken = 1; branch_offset = 16'h0010;
    step("jump_over_branch");
    chk("jump_pc", rom_addr, 32'd7);
    idle_inputs();
    step("after_jump");

    // out-of-range fetch, recovery, and sticky error
    jump = 1; jump_target = 26'd40;
    step("jump_oor");
    idle_inputs();
    step("oor1");
    chk("oor_err", 32'(pc_err), 32'd1);
    chk("oor_hold", rom_addr, 32'd40);
    step("oor2");
    branch_taken = 1; branch_offset = 16'(5 - int'(m_ifpc1));
    step("branch_back");
    chk("back_pc", rom_addr, 32'd5);
    idle_inputs();
    step("resume");
    chk("resume_valid", 32'(if_valid), 32'd1);
    chk("resume_err_sticky", 32'(pc_err), 32'd1);
    rst = 1;
    step("err_clear");
    chk("err_cleared", 32'(pc_err), 32'd0);
    idle_inputs();
    for (int i = 0; i < 4; i++) step("refill");

    // stall with flush: pc holds, instruction killed
    stall = 1; flush = 1;
    step("stall_flush");
    chk("stall_flush_valid", 32'(if_valid), 32'd0);
    chk("stall_flush_pc", rom_addr, 32'd4);
    idle_inputs();
    step("after_stall_flush");

    // reset beats a concurrent jump
    rst = 1; jump = 1; jump_target = 26'd9;
    step("rst_jump");
    chk("rst_jump_pc", rom_addr, 32'd0);
    idle_inputs();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      rst           = ($urandom_range(0, 99) == 0);
      stall         = ($urandom_range(0, 9) < 2);
      flush         = ($urandom_range(0, 9) < 2);
      branch_taken  = ($urandom_range(0, 9) == 0);
      o             = int'($urandom_range(0, 20)) - 10;
      branch_offset = 16'(o);
      jump          = ($urandom_range(0, 11) == 0);
      jump_target   = 26'($urandom_range(0, 39));
      step("rand");
    end
    idle_inputs();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
